// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external ALU, one transaction at a time.
// Each transaction runs IDLE (accept) -> EXEC (drive ALU) -> RESP (hold result).
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration on a tie;
// without it requester 0 always wins a tie and no pointer state exists.
module alu_arbiter #(
    parameter int          DATA_W = 16,
    parameter logic [3:0]  NOP_OP = 4'b1111
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    input  logic              REQ1_VALID,
    output logic              REQ0_READY,
    output logic              REQ1_READY,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic [3:0]        REQ0_OP,
    input  logic [3:0]        REQ1_OP,
    output logic              RSP0_VALID,
    output logic              RSP1_VALID,
    input  logic              RSP0_READY,
    input  logic              RSP1_READY,
    output logic [DATA_W-1:0] RSP_OUT,
    output logic [3:0]        RSP_FLAG,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [3:0]        ALU_S,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic [3:0]        ALU_FLAG
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              gnt_q, gnt_d;
    logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
    logic [3:0]        rsp_flag_q, rsp_flag_d;
    logic              any_s;
    logic              win_s;
`ifdef ALU_ARB_RR_EN
    logic              ptr_q, ptr_d;
`endif

    // Arbitration: pick which valid requester would be accepted in IDLE.
    always_comb begin
        any_s = REQ0_VALID | REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_ARB_RR_EN
            win_s = ptr_q;
`else
            win_s = 1'b0;
`endif
        end else if (REQ1_VALID) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and output decode for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        gnt_d      = gnt_q;
        rsp_out_d  = rsp_out_q;
        rsp_flag_d = rsp_flag_q;
`ifdef ALU_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        ALU_A      = {DATA_W{1'b0}};
        ALU_B      = {DATA_W{1'b0}};
        ALU_S      = NOP_OP;
        case (state_q)
            IDLE: begin
                // READY only rises alongside the winner's VALID, so READY
                // itself marks the handshake; gated off while reset is held.
                if (RST_N && any_s) begin
                    REQ0_READY = ~win_s;
                    REQ1_READY = win_s;
                    gnt_d      = win_s;
                    a_d        = win_s ? REQ1_A  : REQ0_A;
                    b_d        = win_s ? REQ1_B  : REQ0_B;
                    op_d       = win_s ? REQ1_OP : REQ0_OP;
                    state_d    = EXEC;
`ifdef ALU_ARB_RR_EN
                    ptr_d      = ~win_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                ALU_A   = a_q;
                ALU_B   = b_q;
                ALU_S   = op_q;
                state_d = RESP;
                // A no-op never reports whatever the ALU happens to return.
                if (op_q == NOP_OP) begin
                    rsp_out_d  = {DATA_W{1'b0}};
                    rsp_flag_d = 4'b0000;
                end else begin
                    rsp_out_d  = ALU_OUT;
                    rsp_flag_d = ALU_FLAG;
                end
            end
            RESP: begin
                RSP0_VALID = ~gnt_q;
                RSP1_VALID = gnt_q;
                if (gnt_q ? RSP1_READY : RSP0_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            op_q       <= NOP_OP;
            gnt_q      <= 1'b0;
            rsp_out_q  <= {DATA_W{1'b0}};
            rsp_flag_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            gnt_q      <= gnt_d;
            rsp_out_q  <= rsp_out_d;
            rsp_flag_q <= rsp_flag_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer: requester favoured on the next tie.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign RSP_OUT  = rsp_out_q;
    assign RSP_FLAG = rsp_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives ALU_OUT/FLAG,
// and a transaction-level reference model predicts every output each cycle.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, rr0, rr1;
    logic [15:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic        req_rdy0, req_rdy1, rsp_vld0, rsp_vld1;
    logic [15:0] rsp_out, alu_a, alu_b, alu_out;
    logic [3:0]  rsp_flag, alu_s, alu_flag;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en;
    int grants[$];

    // reference model state
    bit          m_busy;
    int          m_age, m_gnt, m_ptr;
    logic [15:0] m_a, m_b, m_out;
    logic [3:0]  m_op, m_flag;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ0_VALID(v0), .REQ1_VALID(v1),
        .REQ0_READY(req_rdy0), .REQ1_READY(req_rdy1),
        .REQ0_A(a0), .REQ0_B(b0), .REQ1_A(a1), .REQ1_B(b1),
        .REQ0_OP(op0), .REQ1_OP(op1),
        .RSP0_VALID(rsp_vld0), .RSP1_VALID(rsp_vld1),
        .RSP0_READY(rr0), .RSP1_READY(rr1),
        .RSP_OUT(rsp_out), .RSP_FLAG(rsp_flag),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_S(alu_s),
        .ALU_OUT(alu_out), .ALU_FLAG(alu_flag)
    );

    // Reference ALU: returns {S,Z,C,V, result}. Op F returns junk with all
    // flags set so that no-op masking in the arbiter is observable.
    function automatic logic [19:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [15:0] o;
        logic        c, v;
        logic [3:0]  f;
        r = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin o = r[15:0]; c = r[16]; v = (a[15] == b[15]) && (o[15] != a[15]); end
            4'd1: begin o = a - b; c = (a < b); v = (a[15] != b[15]) && (o[15] != a[15]); end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = a ^ b;
            4'd15: o = ~a;
            default: o = {a[14:0], a[15]};
        endcase
        f = {o[15], (o == 16'h0000), c, v};
        if (op == 4'd15) f = 4'b1111;
        return {f, o};
    endfunction

    // External ALU seen by the DUT.
    always_comb {alu_flag, alu_out} = ref_alu(alu_s, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance the model.
    task automatic cycle();
        bit any, ex, rs;
        int w;
        @(negedge clk);
        any = rst_n && (v0 || v1);
        if (v0 && v1) w = RR ? m_ptr : 0;
        else          w = v1 ? 1 : 0;
        ex = m_busy && (m_age == 1);
        rs = m_busy && (m_age >= 2);
        if (chk_en) begin
            check("req0_ready", req_rdy0, !m_busy && any && w == 0);
            check("req1_ready", req_rdy1, !m_busy && any && w == 1);
            check("rsp0_valid", rsp_vld0, rs && m_gnt == 0);
            check("rsp1_valid", rsp_vld1, rs && m_gnt == 1);
            check("rsp_out",    rsp_out,  m_out);
            check("rsp_flag",   rsp_flag, m_flag);
            check("alu_a",      alu_a,    ex ? m_a : 16'h0000);
            check("alu_b",      alu_b,    ex ? m_b : 16'h0000);
            check("alu_s",      alu_s,    ex ? m_op : 4'hF);
        end
        if (req_rdy0 && v0) grants.push_back(0);
        if (req_rdy1 && v1) grants.push_back(1);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_out = 16'h0000; m_flag = 4'h0;
        end else if (!m_busy) begin
            if (any) begin
                m_busy = 1'b1; m_age = 1; m_gnt = w; m_ptr = 1 - w;
                m_a  = w ? a1 : a0;
                m_b  = w ? b1 : b0;
                m_op = w ? op1 : op0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            {m_flag, m_out} = (m_op == 4'hF) ? 20'h00000 : ref_alu(m_op, m_a, m_b);
        end else if (m_gnt == 0 ? rr0 : rr1) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic quiet();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; quiet();
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0; op0 = 4'h0; op1 = 4'h0;
        m_busy = 1'b0; m_age = 0; m_gnt = 0; m_ptr = 0;
        m_a = 16'h0; m_b = 16'h0; m_op = 4'hF; m_out = 16'h0; m_flag = 4'h0;
        chk_en = 1'b0;
        cycle();
        chk_en = 1'b1;
        do_reset();

        // Add with signed overflow, accepted in the first cycle after reset.
        v0 = 1'b1; a0 = 16'h7FFF; b0 = 16'h0001; op0 = 4'b0000;
        cycle();
        v0 = 1'b0;
        cycle();
        check("add_out",  rsp_out,  16'h8000);
        check("add_flag", rsp_flag, 4'b1001);
        check("add_vld0", rsp_vld0, 1'b1);
        rr0 = 1'b1; cycle(); rr0 = 1'b0;

        // Subtract to zero, response held while RSP1_READY stays low.
        v1 = 1'b1; a1 = 16'h0005; b1 = 16'h0005; op1 = 4'b0001;
        cycle();
        v1 = 1'b0;
        cycle();
        v0 = 1'b1; rr0 = 1'b1;
        repeat (5) cycle();
        check("sub_out",  rsp_out,  16'h0000);
        check("sub_flag", rsp_flag, 4'b0100);
        check("sub_vld1", rsp_vld1, 1'b1);
        quiet(); rr1 = 1'b1; cycle(); rr1 = 1'b0;

        // Contention with both requesters always valid.
        do_reset();
        grants.delete();
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
        a0 = 16'h1111; b0 = 16'h2222; op0 = 4'd3;
        a1 = 16'hF0F0; b1 = 16'h0FF0; op1 = 4'd4;
        repeat (12) cycle();
        quiet();
        check("grant_cnt", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("grant_order", (i < grants.size()) ? grants[i] : 9, RR ? (i % 2) : 0);
        end

        // Reset during EXEC discards the transaction.
        v0 = 1'b1; a0 = 16'hAAAA; b0 = 16'h5555; op0 = 4'd0;
        cycle();
        v0 = 1'b0; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst_vld0", rsp_vld0, 1'b0);
        check("rst_alus", alu_s, 4'b1111);
        rr0 = 1'b1; rr1 = 1'b1;
        repeat (3) cycle();
        quiet();

        // No-op returns zero result and flags.
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'($urandom); op0 = 4'b1111;
        cycle();
        v0 = 1'b0;
        cycle();
        check("nop_out",  rsp_out,  16'h0000);
        check("nop_flag", rsp_flag, 4'b0000);
        rr0 = 1'b1; cycle(); rr0 = 1'b0;

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            v0  = $urandom_range(0, 1); v1  = $urandom_range(0, 1);
            rr0 = $urandom_range(0, 1); rr1 = $urandom_range(0, 1);
            a0  = 16'($urandom); b0 = 16'($urandom);
            a1  = 16'($urandom); b1 = 16'($urandom);
            op0 = 4'($urandom_range(0, 15)); op1 = 4'($urandom_range(0, 15));
            cycle();
        end
        rst_n = 1'b1; quiet();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU operand/result width (the only supported value is 16).
REQ-002 SHALL have parameter NOP_OP, default 4'b1111, ALU select code meaning "no operation".
REQ-003 SHALL have CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have RST_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 SHALL have REQ0_VALID/REQ1_VALID  input  1  requester n presents an operation.
REQ-006 SHALL have REQ0_READY/REQ1_READY  output  1  arbiter accepts requester n this cycle.
REQ-007 SHALL have REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  16  operands; REQ0_OP/REQ1_OP  input  4  ALU select code.
REQ-008 SHALL have RSP0_VALID/RSP1_VALID  output  1  result for requester n is available.
REQ-009 SHALL have RSP0_READY/RSP1_READY  input  1  requester n consumes the result.
REQ-010 SHALL have RSP_OUT  output  16  result; RSP_FLAG  output  4  {S,Z,C,V}; both are shared by the two requesters.
REQ-011 SHALL have ALU_A, ALU_B  output  16, ALU_S  output  4  drive the shared ALU; ALU_OUT  input  16, ALU_FLAG  input  4  returned from it.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP, with one transaction in flight at a time.
REQ-013 IDLE: REQn_READY SHALL be 1 only for the requester selected by arbitration; all other READY signals are 0.
REQ-014 A handshake (VALID&READY at edge k) SHALL register A, B, OP and the grant ID, and move to EXEC.
REQ-015 EXEC (cycle k+1): ALU_A/ALU_B/ALU_S SHALL be driven from the registers; at edge k+2, ALU_OUT/ALU_FLAG are captured into RSP_OUT/RSP_FLAG and the FSM moves to RESP.
REQ-016 Outside EXEC, ALU_S SHALL equal NOP_OP and ALU_A/ALU_B SHALL be 0.
REQ-017 RESP: only RSPn_VALID of the granted requester SHALL be 1 from cycle k+2, and RSP_OUT/RSP_FLAG are held stable until RSPn_READY=1.
REQ-018 RSPn_VALID&RSPn_READY SHALL return the FSM to IDLE; a new request is accepted no earlier than the following edge (3-cycle minimum per transaction).
REQ-019 If the registered OP equals NOP_OP, the captured RSP_OUT SHALL be 0 and RSP_FLAG 4'b0000, regardless of ALU_FLAG.
REQ-020 REQ VALID SHALL NOT be needed once accepted; a VALID that drops before READY is ignored without error.
REQ-021 Simultaneous REQ0_VALID and REQ1_VALID SHALL be resolved per REQ-026/027; the loser's READY stays 0 and it keeps waiting.
REQ-022 An RSPn_READY asserted while not in RESP, or for the non-granted requester, SHALL be ignored.

Reset
REQ-023 With RST_N=0 at an edge, the FSM SHALL go to IDLE, with all READY/RSP_VALID = 0, RSP_OUT = 0, RSP_FLAG = 0, ALU_A/ALU_B = 0, ALU_S = NOP_OP, and the priority pointer set to requester 0.
REQ-024 A reset during EXEC or RESP SHALL discard the in-flight transaction and produce no response afterwards.
REQ-025 In the first cycle after reset release, IDLE arbitration SHALL apply, so READY may assert in that cycle.

Configuration
REQ-026 With ALU_ARB_RR_EN defined: round-robin arbitration; the pointer is set to the non-granted requester at each accepted handshake, and on a tie the requester at the pointer wins.
REQ-027 Without ALU_ARB_RR_EN: fixed priority; requester 0 always wins a tie, and the pointer logic is absent.

Verification
REQ-028 REQ0: OP=0000, A=16'h7FFF, B=16'h0001 -> RSP0_VALID at k+2, RSP_OUT=16'h8000, RSP_FLAG=4'b1001.
REQ-029 REQ1: OP=0001, A=B=16'h0005, RSP1_READY held 0 for 5 cycles -> RSP_OUT=16'h0000 and RSP_FLAG=4'b0100 stable, RSP1_VALID=1 throughout, REQ0/1_READY=0.
REQ-030 Both VALID held continuously, RSP_READY=1 -> grant order 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0,0 without it.
REQ-031 RST_N=0 for 1 cycle during EXEC -> next cycle state IDLE, RSPn_VALID=0, ALU_S=4'b1111, and no response for that transaction.
REQ-032 REQ0: OP=1111, A=16'h1234 -> RSP_OUT=16'h0000, RSP_FLAG=4'b0000.
